// File: rtl/psm_gen_pkg.sv
// Shared state encoding and default phase durations for the processing state machine.
package psm_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP1  = 2'd1,
    ST_OP2  = 2'd2,
    ST_OP3  = 2'd3
  } state_e;

  localparam int WIDTH_DEF      = 8;
  localparam int OP1_CYCLES_DEF = 10;
  localparam int OP2_CYCLES_DEF = 7;
  localparam int OP3_CYCLES_DEF = 5;
  localparam int CNT_W_DEF      = 8;

endpackage

// File: rtl/psm_phase_timer.sv
// Phase counter: cleared on phase entry, counts while enabled, flags the terminal count.
module psm_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == limit_i);

endmodule

// File: rtl/psm_gen.sv
// Idle -> Op1 -> Op2 -> Op3 processing sequencer with abort, back-to-back restart and Done pulse.
//   state   | meaning
//   ST_IDLE | ready, waiting for start_i
//   ST_OP1  | phase 1, dout = A | B
//   ST_OP2  | phase 2, dout = A ^ B
//   ST_OP3  | phase 3, dout = ~(~A & B); start_i on its last cycle restarts
module psm_gen
  import psm_gen_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int OP1_CYCLES = OP1_CYCLES_DEF,
  parameter int OP2_CYCLES = OP2_CYCLES_DEF,
  parameter int OP3_CYCLES = OP3_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] din1_i,
  input  logic [WIDTH-1:0] din2_i,
  input  logic             start_i,
  input  logic             abort_i,
  output logic             ready_o,
  output logic             op1_o,
  output logic             op2_o,
  output logic             op3_o,
  output logic             done_o,
  output logic [WIDTH-1:0] dout_o
);

  if (OP1_CYCLES < 1 || OP2_CYCLES < 1 || OP3_CYCLES < 1 ||
      (OP1_CYCLES - 1) >= (1 << CNT_W) || (OP2_CYCLES - 1) >= (1 << CNT_W) ||
      (OP3_CYCLES - 1) >= (1 << CNT_W)) begin : g_param_chk
    $fatal(1, "psm_gen: OPn_CYCLES must be >= 1 and OPn_CYCLES-1 must fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] LIM1 = CNT_W'(OP1_CYCLES - 1);
  localparam logic [CNT_W-1:0] LIM2 = CNT_W'(OP2_CYCLES - 1);
  localparam logic [CNT_W-1:0] LIM3 = CNT_W'(OP3_CYCLES - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             done_q, done_d;
  logic             tmr_clear, tmr_enable, tmr_last;
  logic [CNT_W-1:0] tmr_limit;

  psm_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i    (clock_i),
    .rst_i    (reset_i),
    .clear_i  (tmr_clear),
    .enable_i (tmr_enable),
    .limit_i  (tmr_limit),
    .last_o   (tmr_last)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    done_d     = 1'b0;
    tmr_limit  = '0;
    tmr_enable = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_OP1;
          a_d     = din1_i;
          b_d     = din2_i;
        end
      end
      ST_OP1: begin
        tmr_limit  = LIM1;
        tmr_enable = 1'b1;
        if (abort_i)       state_d = ST_IDLE;
        else if (tmr_last) state_d = ST_OP2;
      end
      ST_OP2: begin
        tmr_limit  = LIM2;
        tmr_enable = 1'b1;
        if (abort_i)       state_d = ST_IDLE;
        else if (tmr_last) state_d = ST_OP3;
      end
      ST_OP3: begin
        tmr_limit  = LIM3;
        tmr_enable = 1'b1;
        // Abort beats both completion and the back-to-back restart.
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (tmr_last) begin
          done_d = 1'b1;
          if (start_i) begin
            state_d = ST_OP1;
            a_d     = din1_i;
            b_d     = din2_i;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    tmr_clear = (state_d != state_q) || (state_q == ST_IDLE);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    ready_o = 1'b0;
    op1_o   = 1'b0;
    op2_o   = 1'b0;
    op3_o   = 1'b0;
    dout_o  = '0;
    case (state_q)
      ST_OP1: begin
        op1_o  = 1'b1;
        dout_o = a_q | b_q;
      end
      ST_OP2: begin
        op2_o  = 1'b1;
        dout_o = a_q ^ b_q;
      end
      ST_OP3: begin
        op3_o  = 1'b1;
        dout_o = ~(~a_q & b_q);
      end
      default: ready_o = 1'b1;
    endcase
  end

  assign done_o = done_q;

endmodule

// File: tb/tb_psm_gen.sv
// Bench for psm_gen: default instance plus a 16-bit single-cycle-phase instance, checked against a schedule model.
module tb_psm_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b1, start0 = 1'b0, abort0 = 1'b0;
  logic [7:0] d10 = '0, d20 = '0, dout0;
  logic       ready0, op10, op20, op30, done0;

  logic        rst1 = 1'b1, start1 = 1'b0, abort1 = 1'b0;
  logic [15:0] d11 = '0, d21 = '0, dout1;
  logic        ready1, op11, op21, op31, done1;

  psm_gen u_dut0 (
    .clock_i(clk), .reset_i(rst0), .din1_i(d10), .din2_i(d20),
    .start_i(start0), .abort_i(abort0), .ready_o(ready0), .op1_o(op10),
    .op2_o(op20), .op3_o(op30), .done_o(done0), .dout_o(dout0)
  );

  psm_gen #(.WIDTH(16), .OP1_CYCLES(1), .OP2_CYCLES(1), .OP3_CYCLES(1), .CNT_W(4)) u_dut1 (
    .clock_i(clk), .reset_i(rst1), .din1_i(d11), .din2_i(d21),
    .start_i(start1), .abort_i(abort1), .ready_o(ready1), .op1_o(op11),
    .op2_o(op21), .op3_o(op31), .done_o(done1), .dout_o(dout1)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: a run is a start edge index plus latched operands; the phase
  // follows from how many edges have elapsed since that start edge.
  bit          m_act[2];
  int          m_st[2];
  logic [15:0] m_a[2], m_b[2];
  bit          m_done[2];
  int          cyc = 0;

  function automatic int plen(input int i, input int n);
    if (i == 1) return 1;
    return (n == 1) ? 10 : (n == 2) ? 7 : 5;
  endfunction

  function automatic int ptot(input int i);
    return plen(i, 1) + plen(i, 2) + plen(i, 3);
  endfunction

  task automatic model_step(input int i, input bit r, input bit s, input bit ab,
                            input logic [15:0] x, input logic [15:0] y);
    int k;
    k = cyc - m_st[i];
    if (r) begin
      m_act[i] = 0; m_a[i] = '0; m_b[i] = '0; m_done[i] = 0;
    end else if (!m_act[i]) begin
      m_done[i] = 0;
      if (s) begin m_act[i] = 1; m_st[i] = cyc; m_a[i] = x; m_b[i] = y; end
    end else if (ab) begin
      m_act[i] = 0; m_done[i] = 0;
    end else if (k == ptot(i)) begin
      m_done[i] = 1;
      if (s) begin m_st[i] = cyc; m_a[i] = x; m_b[i] = y; end
      else m_act[i] = 0;
    end else begin
      m_done[i] = 0;
    end
  endtask

  function automatic logic [20:0] mexp(input int i);
    int k, ph;
    logic [15:0] mask, d;
    k = cyc - m_st[i];
    if (!m_act[i])                          ph = 0;
    else if (k <= plen(i, 1))               ph = 1;
    else if (k <= plen(i, 1) + plen(i, 2))  ph = 2;
    else                                    ph = 3;
    mask = (i == 0) ? 16'h00FF : 16'hFFFF;
    case (ph)
      1:       d = m_a[i] | m_b[i];
      2:       d = m_a[i] ^ m_b[i];
      3:       d = m_a[i] | ~m_b[i];
      default: d = '0;
    endcase
    return {ph == 0, ph == 1, ph == 2, ph == 3, m_done[i], d & mask};
  endfunction

  always @(posedge clk) begin
    model_step(0, rst0, start0, abort0, {8'h00, d10}, {8'h00, d20});
    model_step(1, rst1, start1, abort1, d11, d21);
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model0", {11'b0, ready0, op10, op20, op30, done0, 8'h00, dout0}, {11'b0, mexp(0)});
      check("model1", {11'b0, ready1, op11, op21, op31, done1, dout1}, {11'b0, mexp(1)});
      check("onehot0", int'(ready0) + int'(op10) + int'(op20) + int'(op30), 1);
      check("onehot1", int'(ready1) + int'(op11) + int'(op21) + int'(op31), 1);
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    chk_en = 1'b1;
    check("rst_ready", ready0, 1);
    check("rst_dout", dout0, 0);
    check("rst_done", done0, 0);

    // Nominal run with a Start pulse during Op2 that must be ignored.
    d10 = 8'h3C; d20 = 8'hA5; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    for (int j = 0; j < 10; j++) begin
      check("op1_phase", op10, 1); check("op1_dout", dout0, 8'hBD);
      @(negedge clk);
    end
    for (int j = 0; j < 7; j++) begin
      check("op2_phase", op20, 1); check("op2_dout", dout0, 8'h99);
      start0 = (j == 2); d10 = (j == 2) ? 8'h11 : 8'h3C; d20 = (j == 2) ? 8'h22 : 8'hA5;
      @(negedge clk);
    end
    start0 = 1'b0;
    for (int j = 0; j < 5; j++) begin
      check("op3_phase", op30, 1); check("op3_dout", dout0, 8'h7E);
      @(negedge clk);
    end
    check("end_ready", ready0, 1); check("end_done", done0, 1);
    @(negedge clk);
    check("done_pulse", done0, 0);

    // Back-to-back restart on the last Op3 cycle.
    d10 = 8'h12; d20 = 8'h34; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (21) @(negedge clk);
    check("pre_b2b_op3", op30, 1);
    d10 = 8'hFF; d20 = 8'h00; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    check("b2b_op1", op10, 1); check("b2b_dout", dout0, 8'hFF);
    check("b2b_done", done0, 1); check("b2b_ready", ready0, 0);

    // Abort together with Start on the 4th Op2 cycle.
    repeat (13) @(negedge clk);
    check("pre_abort_op2", op20, 1);
    abort0 = 1'b1; start0 = 1'b1;
    @(negedge clk); abort0 = 1'b0; start0 = 1'b0;
    check("abort_ready", ready0, 1); check("abort_dout", dout0, 0); check("abort_done", done0, 0);
    @(negedge clk);
    check("abort_done2", done0, 0);

    // Reset on the 3rd Op1 cycle.
    d10 = 8'h5A; d20 = 8'hC3; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (2) @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk); rst0 = 1'b0;
    check("rst_mid_ready", ready0, 1);
    check("rst_mid_ops", {op10, op20, op30}, 0);
    check("rst_mid_done", done0, 0); check("rst_mid_dout", dout0, 0);
    d10 = 8'h00; d20 = 8'h00; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    check("zero_op1", op10, 1); check("zero_dout", dout0, 8'h00);
    repeat (25) @(negedge clk);

    // Wide instance, single-cycle phases.
    d11 = 16'h1234; d21 = 16'h00FF; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    check("w_op1", {op11, dout1}, {1'b1, 16'h12FF});
    @(negedge clk);
    check("w_op2", {op21, dout1}, {1'b1, 16'h12CB});
    @(negedge clk);
    check("w_op3", {op31, dout1}, {1'b1, 16'hFF34});
    @(negedge clk);
    check("w_done", {ready1, done1}, 2'b11);
    @(negedge clk);

    // Randomized traffic on both instances, checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      start0 = ($urandom_range(0, 3) == 0);
      abort0 = ($urandom_range(0, 29) == 0);
      rst0   = ($urandom_range(0, 149) == 0);
      d10    = 8'($urandom); d20 = 8'($urandom);
      start1 = ($urandom_range(0, 2) == 0);
      abort1 = ($urandom_range(0, 9) == 0);
      rst1   = ($urandom_range(0, 99) == 0);
      d11    = 16'($urandom); d21 = 16'($urandom);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/psm_gen.md
Name: psm_gen

Overview:
- Parametrised next-generation processing state machine: Idle -> Op1 -> Op2 -> Op3 -> Idle, each Op phase lasting a configurable number of cycles.
- Samples two WIDTH-bit operands on Start and drives a phase-specific logic function of them on Dout.
- Adds over the previous generation: width/duration parameters, back-to-back restart, Abort, one-cycle Done pulse, Busy-time Start rejection.
- Sits between an operand source and downstream consumers keyed on Op1/Op2/Op3.

Parameters:
- WIDTH, 8, operand and Dout width (>=1).
- OP1_CYCLES, 10, Op1 duration in cycles (>=1).
- OP2_CYCLES, 7, Op2 duration in cycles (>=1).
- OP3_CYCLES, 5, Op3 duration in cycles (>=1).
- CNT_W, 8, phase counter width; each OPn_CYCLES-1 must fit in CNT_W bits.

Ports:
- Clock  in  1  single clock, all state on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Din1  in  WIDTH  operand A, sampled on accepted Start.
- Din2  in  WIDTH  operand B, sampled on accepted Start.
- Start  in  1  request; accepted only as defined below.
- Abort  in  1  terminate current operation, return to Idle.
- Ready  out  1  high in Idle only.
- Op1, Op2, Op3  out  1 each  one-hot phase indicators.
- Done  out  1  one-cycle pulse on normal completion.
- Dout  out  WIDTH  phase result.

Behaviour:
- Reset (sync, sampled on a Clock edge): state=Idle, counter=0, samples=0, Done=0. Outputs after reset: Ready=1, Op1..Op3=0, Done=0, Dout=0. Reset mid-operation aborts with no Done.
- Phase counter: cleared on every phase entry; increments each cycle in a phase; the phase ends when counter==OPn_CYCLES-1. Op phase n is therefore asserted for exactly OPn_CYCLES cycles.
- Start acceptance:
  - Idle: Start=1 at an edge moves the state to Op1 and latches Din1/Din2 at that edge.
  - Last cycle of Op3: Start=1 with Abort=0 causes back-to-back restart. Next state is Op1, new operands are latched, and Ready stays 0.
  - Any other cycle: Start is ignored and samples are unchanged.
- Total latency: Start edge to Ready=1 is OP1_CYCLES+OP2_CYCLES+OP3_CYCLES+1 cycles (23 at defaults).
- Abort:
  - In any Op phase, Abort=1 at an edge gives next state Idle, counter=0, no Done, samples retained.
  - Abort has priority over counter expiry and back-to-back Start.
  - Ignored in Idle. Abort and Start together in Idle: Start wins.
- Done: registered, high exactly one cycle following the last Op3 cycle when completion was not aborted. This is the first Idle cycle, or the first Op1 cycle of a back-to-back run.
- Combinational outputs, from state and samples (A=sample1, B=sample2):
  - Idle: Ready=1, Op*=0, Dout=0.
  - Op1: Op1=1, Dout=A|B.
  - Op2: Op2=1, Dout=A^B.
  - Op3: Op3=1, Dout=~(~A&B).
  - Ready=0 in all Op states.
- Illegal state encoding: next state Idle, counter 0; outputs as Idle.
- Exactly one of {Ready, Op1, Op2, Op3} is high every cycle.
- Elaboration check: any OPn_CYCLES<1 or OPn_CYCLES-1 >= 2**CNT_W is a fatal error.

Decomposition:
- Shared package psm_gen_pkg:
  - 2-bit state encoding constants (IDLE=0, OP1=1, OP2=2, OP3=3).
  - Default cycle-count constants.
- Sub-module psm_phase_timer (CNT_W):
  - Inputs: clear, enable, limit.
  - Output: last (counter==limit).
  - psm_gen instantiates it once and selects limit = OPn_CYCLES-1 by state.

Test Plan:
- Reset, then Start=1 with Din1=0x3C, Din2=0xA5 (defaults). Required response:
  - Op1 for 10 cycles with Dout=0xBD.
  - Op2 for 7 cycles with Dout=0x99.
  - Op3 for 5 cycles with Dout=0x7E.
  - Then Ready=1, Done=1 for one cycle, 23 cycles after the Start edge.
- Change Din1/Din2 and pulse Start during Op2 -> no effect; Dout is still 0x99 and sequence timing is unchanged.
- Assert Start with Din1=0xFF, Din2=0x00 on the last Op3 cycle. Required response:
  - Next cycle Op1=1 with Dout=0xFF, Done=1 for that cycle, and Ready never rises.
- Abort=1 on the 4th Op2 cycle, simultaneously with Start=1 -> next cycle Ready=1, Dout=0, Done stays 0.
- Reset=1 on the 3rd Op1 cycle -> next cycle Ready=1, all Op=0, Done=0, Dout=0. A following Start with 0x00/0x00 gives Op1 Dout=0x00.
- WIDTH=16, OP1/2/3_CYCLES=1 with Din1=0x1234, Din2=0x00FF -> one cycle each:
  - Op1: Dout=0x12FF.
  - Op2: Dout=0x12CB.
  - Op3: Dout=0xFF34.
  - Done follows, 4 cycles after Start.
